// File: rtl/painter_key_event_master.sv
// ---------------------------------------------------------------------------
// painter_key_event_master
//
// Avalon-MM master for the 4-bit key PIO slave. After reset it programs the
// slave's irq_mask. Whenever the slave raises key_irq it reads edge_capture,
// clears it, and hands the pressed keys to the painter control logic as one
// event on a valid/ready stream. Independently, a free-running poll counter
// requests a periodic read of the data register so key_level tracks the raw
// in_port value.
//
// Ports
//   clk, reset          single clock, asynchronous active-high reset
//   avm_address[1:0]    word address to the key PIO slave (registered)
//   avm_chipselect      slave select, high for every read/write cycle (registered)
//   avm_write_n         active-low write strobe (registered)
//   avm_writedata[31:0] write data, upper 28 bits always zero (registered)
//   avm_readdata[31:0]  slave read data, valid one clk after the address
//   key_irq             slave interrupt (edge_capture & irq_mask nonzero)
//   evt_valid/evt_ready event handshake, transfer on valid & ready
//   evt_keys[3:0]       keys that saw a press since the last clear
//   key_level[3:0]      raw in_port from the last poll (1 = released)
//   init_done           high once the irq_mask write has completed
//
// Bus timing: the bus registers are loaded on the edge that enters a state,
// so each access is visible on the bus for exactly the clk spent in the
// state that owns it (INIT's write shows during the first IDLE clk).
// ---------------------------------------------------------------------------
module painter_key_event_master #(
    parameter logic [3:0] KEY_MASK    = 4'hF,
    parameter int         POLL_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        key_irq,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_keys,
    output logic [3:0]  key_level,
    output logic        init_done
);

    localparam int               CNT_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_RD_EDGE   = 3'd2,
        ST_RD_EDGE_W = 3'd3,
        ST_CLR       = 3'd4,
        ST_EMIT      = 3'd5,
        ST_RD_LVL    = 3'd6,
        ST_RD_LVL_W  = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       addr_q, addr_d;
    logic             cs_q, cs_d;
    logic             write_n_q, write_n_d;
    logic [3:0]       wdata_q, wdata_d;
    logic             evt_valid_q, evt_valid_d;
    logic [3:0]       evt_keys_q, evt_keys_d;
    logic [3:0]       key_level_q, key_level_d;
    logic             init_done_q, init_done_d;
    logic [3:0]       edge_q, edge_d;
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic             poll_pending_q, poll_pending_d;
    logic             poll_wrap_s;
    logic             lvl_done_s;
    logic             readdata_unused_s;

    // Upper readdata bits carry nothing for a 4-key PIO.
    assign readdata_unused_s = ^avm_readdata[31:4];

    // Poll counter free-runs in every state; a wrap raises a single sticky request.
    always_comb begin
        poll_wrap_s = 1'b0;
        if (poll_cnt_q == CNT_LAST) begin
            poll_cnt_d  = {CNT_W{1'b0}};
            poll_wrap_s = 1'b1;
        end else begin
            poll_cnt_d = poll_cnt_q + CNT_W'(1);
        end
        // A new wrap wins over the clear so a request is never silently lost.
        if (poll_wrap_s) begin
            poll_pending_d = 1'b1;
        end else if (lvl_done_s) begin
            poll_pending_d = 1'b0;
        end else begin
            poll_pending_d = poll_pending_q;
        end
    end

    // Next-state and next-bus-cycle logic; bus defaults to an idle cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cs_d        = 1'b0;
        write_n_d   = 1'b1;
        wdata_d     = 4'h0;
        evt_valid_d = evt_valid_q;
        evt_keys_d  = evt_keys_q;
        key_level_d = key_level_q;
        init_done_d = init_done_q;
        edge_d      = edge_q;
        lvl_done_s  = 1'b0;
        case (state_q)
            ST_INIT: begin
                addr_d    = ADDR_MASK;
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                wdata_d   = KEY_MASK;
                state_d   = ST_IDLE;
            end
            ST_IDLE: begin
                // The mask write is on the bus during this clk and completes at its end.
                init_done_d = 1'b1;
                if (key_irq) begin
                    addr_d  = ADDR_EDGE;
                    cs_d    = 1'b1;
                    state_d = ST_RD_EDGE;
                end else if (poll_pending_q) begin
                    addr_d  = ADDR_DATA;
                    cs_d    = 1'b1;
                    state_d = ST_RD_LVL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_EDGE: begin
                state_d = ST_RD_EDGE_W;
            end
            ST_RD_EDGE_W: begin
                edge_d    = avm_readdata[3:0];
                addr_d    = ADDR_EDGE;
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                state_d   = ST_CLR;
            end
            ST_CLR: begin
                // A spurious irq (nothing captured) returns silently.
                if (edge_q != 4'h0) begin
                    evt_valid_d = 1'b1;
                    evt_keys_d  = edge_q;
                    state_d     = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (evt_valid_q && evt_ready) begin
                    evt_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_RD_LVL: begin
                state_d = ST_RD_LVL_W;
            end
            ST_RD_LVL_W: begin
                key_level_d = avm_readdata[3:0];
                lvl_done_s  = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State, bus and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_INIT;
            addr_q         <= 2'd0;
            cs_q           <= 1'b0;
            write_n_q      <= 1'b1;
            wdata_q        <= 4'h0;
            evt_valid_q    <= 1'b0;
            evt_keys_q     <= 4'h0;
            key_level_q    <= 4'hF;
            init_done_q    <= 1'b0;
            edge_q         <= 4'h0;
            poll_cnt_q     <= {CNT_W{1'b0}};
            poll_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            cs_q           <= cs_d;
            write_n_q      <= write_n_d;
            wdata_q        <= wdata_d;
            evt_valid_q    <= evt_valid_d;
            evt_keys_q     <= evt_keys_d;
            key_level_q    <= key_level_d;
            init_done_q    <= init_done_d;
            edge_q         <= edge_d;
            poll_cnt_q     <= poll_cnt_d;
            poll_pending_q <= poll_pending_d;
        end
    end

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_writedata  = {28'h0000000, wdata_q};
    assign evt_valid      = evt_valid_q;
    assign evt_keys       = evt_keys_q;
    assign key_level      = key_level_q;
    assign init_done      = init_done_q;

endmodule
